// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache.
// Holds TRUE/FALSE, default geometry and the tag-width helper.
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ICACHE_INDEX_BITS = 8;
    localparam int ICACHE_TAG_TOP    = 17;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } ic_state_t;

    function automatic int tag_width(input int index_bits);
        return ICACHE_TAG_TOP - (index_bits + 2) + 1;
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Single outstanding refill; flush and freeze from the pipeline.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        roll,
    input  logic        IF_flag,
    input  logic [31:0] IF_addr,
    output logic        IF_valid,
    output logic [31:0] IF_inst,
    output logic        MC_flag,
    output logic [31:0] MC_addr,
    input  logic        MC_commit,
    input  logic [31:0] MC_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TW    = tag_width(INDEX_BITS);

    ic_state_t state_q, state_d;

    logic [LINES-1:0]      valid_q;
    logic [TW-1:0]         tag_q  [LINES];
    logic [31:0]           data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fidx;
    logic [TW-1:0]         tag;
    logic [TW-1:0]         ftag;
    logic                  hit;
    logic                  lookup;
    logic                  miss;
    logic                  fill;
    logic                  unused;

    assign idx  = IF_addr[INDEX_BITS+1:2];
    assign tag  = IF_addr[ICACHE_TAG_TOP:INDEX_BITS+2];
    assign fidx = MC_addr[INDEX_BITS+1:2];
    assign ftag = MC_addr[ICACHE_TAG_TOP:INDEX_BITS+2];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);

    assign unused = ^{IF_addr[31:ICACHE_TAG_TOP+1], IF_addr[1:0],
                      MC_addr[31:ICACHE_TAG_TOP+1], MC_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // roll wins over rdy; rdy low freezes the walk entirely
    always_comb begin
        state_d = state_q;
        lookup  = FALSE;
        miss    = FALSE;
        fill    = FALSE;
        if (roll) begin
            state_d = IDLE;
        end else if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (IF_flag) begin
                        if (hit) begin
                            lookup = TRUE;
                        end else begin
                            miss    = TRUE;
                            state_d = MISS;
                        end
                    end
                end
                MISS: begin
                    if (MC_commit) begin
                        fill    = TRUE;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            IF_valid <= FALSE;
            IF_inst  <= '0;
            MC_flag  <= FALSE;
            MC_addr  <= '0;
        end else if (roll) begin
            IF_valid <= FALSE;
            MC_flag  <= FALSE;
            MC_addr  <= '0;
        end else if (rdy) begin
            IF_valid <= lookup | fill;
            if (lookup) IF_inst <= data_q[idx];
            if (fill)   IF_inst <= MC_data;
            if (miss) begin
                MC_flag <= TRUE;
                MC_addr <= IF_addr;
            end else if (fill) begin
                MC_flag <= FALSE;
            end
        end else begin
            IF_valid <= FALSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       valid_q       <= '0;
        else if (fill) valid_q[fidx] <= TRUE;
    end

    // data and tag need no reset: valid_q guards every read
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[fidx] <= MC_data;
            tag_q[fidx]  <= ftag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected words queued at request,
// popped when IF_valid pulses.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        roll;
    logic        IF_flag;
    logic [31:0] IF_addr;
    logic        IF_valid;
    logic [31:0] IF_inst;
    logic        MC_flag;
    logic [31:0] MC_addr;
    logic        MC_commit;
    logic [31:0] MC_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .roll     (roll),
        .IF_flag  (IF_flag),
        .IF_addr  (IF_addr),
        .IF_valid (IF_valid),
        .IF_inst  (IF_inst),
        .MC_flag  (MC_flag),
        .MC_addr  (MC_addr),
        .MC_commit(MC_commit),
        .MC_data  (MC_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (IF_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                check("if_inst", IF_inst, exp_q.pop_front());
            end
        end
    end

    task automatic fetch_miss(input logic [31:0] addr,
                              input logic [31:0] data, input int lat);
        @(negedge clk);
        IF_flag = 1'b1;
        IF_addr = addr;
        @(negedge clk);
        IF_flag = 1'b0;
        check("miss_mc_flag", {31'd0, MC_flag}, 32'd1);
        check("miss_mc_addr", MC_addr, addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("hold_mc_flag", {31'd0, MC_flag}, 32'd1);
            check("hold_mc_addr", MC_addr, addr);
        end
        MC_commit = 1'b1;
        MC_data   = data;
        exp_q.push_back(data);
        @(negedge clk);
        MC_commit = 1'b0;
        check("fill_mc_flag", {31'd0, MC_flag}, 32'd0);
    endtask

    task automatic fetch_hit(input logic [31:0] addr,
                             input logic [31:0] data);
        @(negedge clk);
        IF_flag = 1'b1;
        IF_addr = addr;
        exp_q.push_back(data);
        @(negedge clk);
        IF_flag = 1'b0;
        check("hit_mc_flag", {31'd0, MC_flag}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rdy       = 1'b1;
        roll      = 1'b0;
        IF_flag   = 1'b0;
        IF_addr   = '0;
        MC_commit = 1'b0;
        MC_data   = '0;
        repeat (2) @(negedge clk);
        check("rst_if_valid", {31'd0, IF_valid}, 32'd0);
        check("rst_if_inst", IF_inst, 32'd0);
        check("rst_mc_flag", {31'd0, MC_flag}, 32'd0);
        check("rst_mc_addr", MC_addr, 32'd0);
        rst = 1'b0;

        fetch_miss(32'h0, 32'h0000_0013, 2);
        fetch_hit(32'h0, 32'h0000_0013);
        fetch_miss(32'h400, 32'h0010_0093, 1);
        fetch_miss(32'h0, 32'h0000_0013, 0);

        // flush coinciding with refill: nothing delivered or written
        @(negedge clk);
        IF_flag = 1'b1;
        IF_addr = 32'h8;
        @(negedge clk);
        IF_flag = 1'b0;
        check("roll_pre_flag", {31'd0, MC_flag}, 32'd1);
        roll      = 1'b1;
        MC_commit = 1'b1;
        MC_data   = 32'hDEAD_BEEF;
        @(negedge clk);
        roll      = 1'b0;
        MC_commit = 1'b0;
        check("roll_mc_flag", {31'd0, MC_flag}, 32'd0);
        check("roll_mc_addr", MC_addr, 32'd0);

        fetch_miss(32'h4, 32'h0020_0113, 1);
        fetch_miss(32'h8, 32'h0030_0193, 1);

        @(negedge clk);
        IF_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IF_addr = 32'(i * 4);
            exp_q.push_back(i == 0 ? 32'h0000_0013 :
                            i == 1 ? 32'h0020_0113 : 32'h0030_0193);
            @(negedge clk);
            check("b2b_mc_flag", {31'd0, MC_flag}, 32'd0);
        end
        IF_flag = 1'b0;
        @(negedge clk);

        // freeze during a pending miss, commit offered while frozen
        @(negedge clk);
        IF_flag = 1'b1;
        IF_addr = 32'h10;
        @(negedge clk);
        IF_flag = 1'b0;
        rdy       = 1'b0;
        MC_commit = 1'b1;
        MC_data   = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MC_commit = 1'b0;
            check("frz_mc_flag", {31'd0, MC_flag}, 32'd1);
            check("frz_mc_addr", MC_addr, 32'h10);
        end
        rdy       = 1'b1;
        MC_commit = 1'b1;
        MC_data   = 32'h0040_0213;
        exp_q.push_back(32'h0040_0213);
        @(negedge clk);
        MC_commit = 1'b0;
        check("frz_done_flag", {31'd0, MC_flag}, 32'd0);
        fetch_hit(32'h10, 32'h0040_0213);

        // reset abandons refill; late commit ignored; lines invalidated
        @(negedge clk);
        IF_flag = 1'b1;
        IF_addr = 32'h20;
        @(negedge clk);
        IF_flag = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_mc_flag", {31'd0, MC_flag}, 32'd0);
        check("rst2_mc_addr", MC_addr, 32'd0);
        MC_commit = 1'b1;
        MC_data   = 32'h5555_5555;
        @(negedge clk);
        MC_commit = 1'b0;
        check("idle_commit_flag", {31'd0, MC_flag}, 32'd0);
        fetch_miss(32'h0, 32'h0000_0013, 1);

        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 8, number of line-index bits (2^INDEX_BITS lines, one 32-bit word per line).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global ready; low freezes all state.
REQ-005 roll  input  1  pipeline flush from commit stage.
REQ-006 IF_flag  input  1  fetch request from instruction-fetch stage.
REQ-007 IF_addr  input  32  fetch byte address; bits [1:0] are always 0.
REQ-008 IF_valid  output  1  one-cycle pulse: IF_inst is valid for the pending request.
REQ-009 IF_inst  output  32  fetched instruction word.
REQ-010 MC_flag  output  1  memory-controller read request (to IC_flag).
REQ-011 MC_addr  output  32  word address for refill (to IC_addr).
REQ-012 MC_commit  input  1  one-cycle refill-done pulse (from IC_commit).
REQ-013 MC_data  input  32  refill word, valid with MC_commit (from IC_data).

Function
REQ-014 Direct-mapped: index = IF_addr[INDEX_BITS+1:2]; tag = IF_addr[17:INDEX_BITS+2]; per line one valid bit, tag, 32-bit data.
REQ-015 States: IDLE, MISS.
REQ-016 IDLE, IF_flag=1, line valid and tag equal (hit): next cycle IF_valid=1, IF_inst=line data; state stays IDLE.
REQ-017 IDLE, IF_flag=1, miss: latch IF_addr; next cycle MC_flag=1, MC_addr=latched addr, IF_valid=0; go MISS.
REQ-018 MISS: MC_flag and MC_addr held stable until the cycle MC_commit=1 is sampled; IF_flag/IF_addr ignored.
REQ-019 MISS, MC_commit=1: write MC_data, tag, valid=1 into indexed line; next cycle IF_valid=1, IF_inst=MC_data, MC_flag=0; go IDLE.
REQ-020 Hit latency 1 cycle; miss latency = memory-controller latency + 1 cycle.
REQ-021 IF_valid is a single-cycle pulse; deasserts the cycle after unless a new hit is served.
REQ-022 Back-to-back hits: IF_flag held with new IF_addr each cycle yields IF_valid every cycle.
REQ-023 roll=1 (any state): next cycle IF_valid=0, MC_flag=0, MC_addr=0, state IDLE; no line written, even if MC_commit coincides; array contents retained.
REQ-024 roll has priority over rdy; rdy=0 without roll: state, latched address and array held, IF_valid=0, MC_flag/MC_addr held.
REQ-025 IF_flag=0 in IDLE: IF_valid=0, MC_flag=0.
REQ-026 MC_commit sampled in IDLE is ignored.
REQ-027 Same-cycle refill write and new lookup cannot occur (refill returns to IDLE first).

Reset
REQ-028 rst=1: state IDLE, all valid bits 0, IF_valid=0, IF_inst=0, MC_flag=0, MC_addr=0.
REQ-029 rst mid-MISS abandons refill; a subsequent MC_commit in IDLE is ignored.
REQ-030 rst has priority over roll and rdy.

Structure
REQ-031 Shared header define.v holds TRUE/FALSE, ICACHE INDEX_BITS default and tag-width constant.
REQ-032 Single module; the data/tag/valid arrays are inline register arrays, no sub-module.

Verification
REQ-033 After reset, fetch 0x00000000 -> MC_flag=1, MC_addr=0x0; MC_commit with MC_data=0x00000013 -> next cycle IF_valid=1, IF_inst=0x00000013.
REQ-034 Refetch 0x00000000 -> IF_valid=1 one cycle later, IF_inst=0x00000013, MC_flag stays 0.
REQ-035 Fetch 0x00000400 (same index, different tag) -> miss, MC_addr=0x400; after refill 0x00100093, fetch 0x0 misses again.
REQ-036 Miss on 0x8 pending, roll=1 same cycle as MC_commit (data 0xDEADBEEF) -> MC_flag=0, IF_valid=0, later fetch 0x8 misses.
REQ-037 Miss pending, rdy=0 for 3 cycles -> MC_flag/MC_addr unchanged, IF_valid=0; commit after rdy=1 completes normally.
REQ-038 Hits on 0x0,0x4,0x8 in consecutive cycles (all preloaded) -> IF_valid high 3 consecutive cycles with matching words.
